i2c_target: RTL and testbench

// - I2C/SCCB responder (target). The bench-side counterpart of the camera-config
//   I2C initiator; it also serves as an on-FPGA register endpoint.
// - Oversamples scl/sda on clk_i, detects START/STOP, matches a 7-bit address and ACKs it.
// - Receives a register-address byte, then data bytes, and issues one-cycle register writes.
// - Serves reads from a synchronous register port. Register address auto-increments.

---
 rtl/i2c_target_if.sv | 22 ++
 rtl/i2c_target.sv | 158 +++++++++++++++
 tb/tb_i2c_target.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// i2c_target_if: bus pins and synchronous register port of the I2C target
interface i2c_target_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe_o;
    logic       wr_en_o;
    logic [7:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic       rd_en_o;
    logic [7:0] rd_addr_o;
    logic [7:0] rd_data_i;
    logic       busy_o;
    logic       done_o;
    modport slave (
        input  scl_i, sda_i, rd_data_i,
        output sda_oe_o, wr_en_o, wr_addr_o, wr_data_o, rd_en_o, rd_addr_o, busy_o, done_o
    );
    modport master (
        output scl_i, sda_i, rd_data_i,
        input  sda_oe_o, wr_en_o, wr_addr_o, wr_data_o, rd_en_o, rd_addr_o, busy_o, done_o
    );
endinterface

// File: rtl/i2c_target.sv
// i2c_target: oversampling I2C/SCCB responder with auto-incrementing register pointer
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h21,
    parameter int          SYNC_STAGES = 2
) (
    input logic         clk_i,
    input logic         reset_i,
    i2c_target_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_e;
    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d, ptr_q, ptr_d;
    logic [7:0]             wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic                   rw_q, rw_d, oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic                   wr_en_q, wr_en_d, rd_en_q, rd_en_d, load_q;
    logic                   scl_s, sda_s, scl_rise, scl_fall, bus_start, bus_stop, byte_done;
    logic [7:0]             rx_byte;
    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign bus_start = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign bus_stop  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};
    assign byte_done = scl_rise & (cnt_q == 3'd0);
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            cnt_q      <= 3'd7;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            load_q     <= rd_en_q;
        end
    end
    // In the ACK states oe_q doubles as the phase marker: first fall drives, second fall ends the bit
    always_comb begin
        state_d = state_q;
        if (bus_start) state_d = ADDR;
        else if (bus_stop) state_d = IDLE;
        else begin
            case (state_q)
                ADDR:               if (byte_done) state_d = (rx_byte[7:1] == TARGET_ADDR) ? ADDR_ACK : IDLE;
                ADDR_ACK:           if (scl_fall && oe_q) state_d = rw_q ? RDATA : REG;
                REG:                if (byte_done) state_d = REG_ACK;
                REG_ACK, WDATA_ACK: if (scl_fall && oe_q) state_d = WDATA;
                WDATA:              if (byte_done) state_d = WDATA_ACK;
                RDATA:              if (scl_fall && !load_q && cnt_q == 3'd0) state_d = RDATA_ACK;
                RDATA_ACK:          if (scl_fall) state_d = shift_q[0] ? IDLE : RDATA;
                default: ;
            endcase
        end
    end
    // The bit counter wraps 0 -> 7 on the last bit, so it is ready for the next byte
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        if (bus_start) begin
            cnt_d = 3'd7;
            oe_d  = 1'b0;
        end else if (bus_stop) begin
            oe_d   = 1'b0;
            busy_d = 1'b0;
            done_d = busy_q;
        end else begin
            case (state_q)
                ADDR, REG, WDATA: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q - 3'd1;
                    if (byte_done && state_q == ADDR && rx_byte[7:1] == TARGET_ADDR) begin
                        busy_d = 1'b1;
                        rw_d   = rx_byte[0];
                    end
                    if (byte_done && state_q == REG) ptr_d = rx_byte;
                    if (byte_done && state_q == WDATA) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = rx_byte;
                        ptr_d     = ptr_q + 8'd1;
                    end
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                    oe_d    = ~oe_q;
                    rd_en_d = oe_q & rw_q & (state_q == ADDR_ACK);
                end
                RDATA: begin
                    if (load_q) begin
                        shift_d = bus.rd_data_i;
                        oe_d    = ~bus.rd_data_i[7];
                    end else if (scl_fall) begin
                        oe_d    = (cnt_q != 3'd0) & ~shift_q[6];
                        shift_d = {shift_q[6:0], 1'b0};
                        cnt_d   = cnt_q - 3'd1;
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) shift_d = rx_byte;
                    if (scl_fall && !shift_q[0]) begin
                        ptr_d   = ptr_q + 8'd1;
                        rd_en_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.sda_oe_o  = oe_q;
    assign bus.wr_en_o   = wr_en_q;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;
    assign bus.rd_en_o   = rd_en_q;
    assign bus.rd_addr_o = ptr_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-master driven bench with a transaction-level model of the register pointer
module tb_i2c_target;
    localparam int Q = 6;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic m_low = 1'b0;
    i2c_target_if bus ();
    i2c_target #(.TARGET_ADDR(7'h21), .SYNC_STAGES(2)) dut (.clk_i(clk), .reset_i(reset_i), .bus(bus));
    always #5 clk = ~clk;
    assign bus.sda_i = ~(m_low | bus.sda_oe_o);
    logic [7:0]  mem [256];
    logic [7:0]  dat [8];
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    int          done_cnt = 0, busy_cnt = 0, oe_cnt = 0, oe_hi_chg = 0;
    logic        oe_prev = 1'b0, scl_prev = 1'b1;
    int          n_cmp = 0, n_err = 0;
    logic [7:0]  m_ptr = 8'h00;
    always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= mem[bus.rd_addr_o];
    always begin
        @(posedge clk);
        #1;
        if (bus.wr_en_o) wr_q.push_back({bus.wr_addr_o, bus.wr_data_o});
        if (bus.rd_en_o) rd_q.push_back(bus.rd_addr_o);
        if (bus.done_o) done_cnt++;
        if (bus.busy_o) busy_cnt++;
        if (bus.sda_oe_o) oe_cnt++;
        if (bus.sda_oe_o !== oe_prev && scl_prev && bus.scl_i) oe_hi_chg++;
        oe_prev  = bus.sda_oe_o;
        scl_prev = bus.scl_i;
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic bit_io(input logic b, output logic r);
        cyc(Q); m_low = ~b;
        cyc(Q); bus.scl_i = 1'b1;
        cyc(Q); r = bus.sda_i;
        cyc(Q); bus.scl_i = 1'b0;
    endtask
    task automatic bus_start;
        m_low = 1'b0;
        cyc(Q); bus.scl_i = 1'b1;
        cyc(Q); m_low = 1'b1;
        cyc(Q); bus.scl_i = 1'b0;
    endtask
    task automatic bus_stop;
        cyc(Q); m_low = 1'b1;
        cyc(Q); bus.scl_i = 1'b1;
        cyc(Q); m_low = 1'b0;
        cyc(4 * Q);
    endtask
    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, r);
        ack = ~r;
    endtask
    task automatic rd_byte(input logic mack, output logic [7:0] v);
        logic r;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_io(1'b1, r);
            v = {v[6:0], r};
        end
        bit_io(~mack, r);
    endtask
    // A matched write lands data byte i at register (reg + i) mod 256; anything else is ignored
    task automatic do_write(input logic [7:0] a, input logic [7:0] r, input int nd, input string tag);
        logic ack, match;
        int w0, d0, b0;
        match = (a[7:1] == 7'h21) && !a[0];
        w0 = wr_q.size(); d0 = done_cnt; b0 = busy_cnt;
        bus_start;
        wr_byte(a, ack); chk($sformatf("%s addr ack", tag), ack, match);
        wr_byte(r, ack); chk($sformatf("%s reg ack", tag), ack, match);
        for (int i = 0; i < nd; i++) begin
            wr_byte(dat[i], ack); chk($sformatf("%s data%0d ack", tag, i), ack, match);
        end
        bus_stop;
        chk($sformatf("%s writes", tag), wr_q.size() - w0, match ? nd : 0);
        for (int i = 0; i < nd && w0 + i < wr_q.size(); i++)
            chk($sformatf("%s write%0d", tag, i), wr_q[w0 + i], {8'(r + i), dat[i]});
        chk($sformatf("%s done", tag), done_cnt - d0, match);
        chk($sformatf("%s busy seen", tag), busy_cnt > b0, match);
        chk($sformatf("%s busy end", tag), bus.busy_o, 1'b0);
        if (match) m_ptr = 8'(r + nd);
    endtask
    // Reads start at the pointer and advance only on a master ACK; the final byte is NACKed
    task automatic do_read(input logic set, input logic [7:0] r, input int nr, input string tag);
        logic ack;
        logic [7:0] v;
        int r0, d0;
        r0 = rd_q.size(); d0 = done_cnt;
        bus_start;
        if (set) begin
            wr_byte(8'h42, ack); chk($sformatf("%s waddr ack", tag), ack, 1'b1);
            wr_byte(r, ack); chk($sformatf("%s reg ack", tag), ack, 1'b1);
            bus_start;
            m_ptr = r;
        end
        wr_byte(8'h43, ack); chk($sformatf("%s raddr ack", tag), ack, 1'b1);
        for (int i = 0; i < nr; i++) begin
            rd_byte(i < nr - 1, v);
            chk($sformatf("%s byte%0d", tag, i), v, mem[8'(m_ptr + i)]);
        end
        bus_stop;
        chk($sformatf("%s reads", tag), rd_q.size() - r0, nr);
        for (int i = 0; i < nr && r0 + i < rd_q.size(); i++)
            chk($sformatf("%s rd_addr%0d", tag, i), rd_q[r0 + i], 8'(m_ptr + i));
        chk($sformatf("%s done", tag), done_cnt - d0, 1);
        m_ptr = 8'(m_ptr + nr - 1);
    endtask
    initial begin
        int k, n, w0, d0, o0;
        logic ack, r;
        logic [7:0] a;
        bus.scl_i = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        cyc(4);
        chk("rst sda_oe", bus.sda_oe_o, 1'b0);
        chk("rst wr_en", bus.wr_en_o, 1'b0);
        chk("rst rd_en", bus.rd_en_o, 1'b0);
        chk("rst busy", bus.busy_o, 1'b0);
        chk("rst done", bus.done_o, 1'b0);
        chk("rst ptr", bus.rd_addr_o, 8'h00);
        chk("rst wr_addr", bus.wr_addr_o, 8'h00);
        chk("rst wr_data", bus.wr_data_o, 8'h00);
        reset_i = 1'b0;
        cyc(4);
        dat[0] = 8'h80;
        do_write(8'h42, 8'h12, 1, "basic");
        dat[0] = 8'hAA; dat[1] = 8'h55;
        do_write(8'h42, 8'hFF, 2, "wrap");
        o0 = oe_cnt;
        dat[0] = 8'h99;
        do_write(8'h44, 8'h10, 1, "wrong");
        chk("wrong sda_oe", oe_cnt - o0, 0);
        mem[8'h0A] = 8'h5C; mem[8'h0B] = 8'h3E;
        do_read(1'b1, 8'h0A, 2, "read");
        w0 = wr_q.size(); d0 = done_cnt;
        bus_start;
        wr_byte(8'h42, ack); chk("part addr ack", ack, 1'b1);
        wr_byte(8'h33, ack); chk("part reg ack", ack, 1'b1);
        bit_io(1'b1, r); bit_io(1'b0, r); bit_io(1'b1, r); bit_io(1'b1, r);
        bus_stop;
        chk("part writes", wr_q.size() - w0, 0);
        chk("part done", done_cnt - d0, 1);
        chk("part busy", bus.busy_o, 1'b0);
        m_ptr = 8'h33;
        do_read(1'b0, 8'h00, 2, "curread");
        d0 = done_cnt;
        bus_start;
        for (int i = 7; i >= 0; i--) bit_io(i == 6 || i == 1 ? 1'b1 : 1'b0, r);
        cyc(Q);
        m_low = 1'b0;
        chk("ack before reset", bus.sda_oe_o, 1'b1);
        reset_i = 1'b1;
        cyc(1);
        reset_i = 1'b0;
        chk("sda after reset", bus.sda_oe_o, 1'b0);
        cyc(Q); bus.scl_i = 1'b1;
        cyc(2 * Q); bus.scl_i = 1'b0;
        bus_stop;
        chk("reset no done", done_cnt - d0, 0);
        chk("reset busy", bus.busy_o, 1'b0);
        m_ptr = 8'h00;
        dat[0] = 8'($urandom); dat[1] = 8'($urandom);
        do_write(8'h42, 8'($urandom), 2, "post reset");
        for (int t = 0; t < 10; t++) begin
            k = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) dat[i] = 8'($urandom);
            a = {7'($urandom), 1'b0};
            if (a[7:1] == 7'h21) a[7] = ~a[7];
            case (k)
                0: do_write(8'h42, 8'($urandom), n, $sformatf("rnd%0d write", t));
                1: do_write(a, 8'($urandom), n, $sformatf("rnd%0d foreign", t));
                2: do_read(1'b1, 8'($urandom), n, $sformatf("rnd%0d read", t));
                default: do_read(1'b0, 8'h00, n, $sformatf("rnd%0d curread", t));
            endcase
        end
        chk("sda_oe moved with scl high", oe_hi_chg, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
